mem_arbiter: RTL and testbench

- Arbitrates the single unified memory port between two requesters: the CPU datapath (driven by the controller's mem_read / mem_write / mem_wrbits) and a host loader/debug port.
- Sequences each access through a fixed wait-state count, returns read data with a one-cycle ack, and drives a stall flag so the phase generator holds cstate while the CPU waits.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_arb_rr_pick2.sv | 16 +
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/owner encodings and default latencies for mem_arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;
  typedef enum logic {
    CPU  = 1'b0,
    HOST = 1'b1
  } owner_t;
  localparam int unsigned DEF_RD_LAT = 2;
  localparam int unsigned DEF_WR_LAT = 1;
  localparam int unsigned CNT_W      = 3;
endpackage

// File: rtl/mem_arb_rr_pick2.sv
// rr_pick2: two-way round-robin selector
//   eligible[0] = cpu, eligible[1] = host; last_grant = previous winner
//   grant_valid = any eligible; grant_owner = winner (the non-last one on a tie)
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] eligible,
  input  owner_t     last_grant,
  output logic       grant_valid,
  output owner_t     grant_owner
);
  always_comb begin
    grant_valid = |eligible;
    grant_owner = (eligible == 2'b11) ? owner_t'(~last_grant) : owner_t'(eligible[1]);
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates the unified memory port between the CPU and a host loader
//   clock/reset    : rising-edge clock, asynchronous active-low reset
//   cpu_* / host_* : request (req, we, addr, wdata, wrbits) in; ack pulse and rdata out
//   host_lock      : blocks CPU grants (loader mode)
//   cpu_stall      : cpu_req & ~cpu_ack, holds the phase generator
//   mem_*          : memory port (addr, wdata, wrbits, read/write strobes, rdata)
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned RD_LAT = DEF_RD_LAT,
  parameter int unsigned WR_LAT = DEF_WR_LAT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wrbits,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [31:0] host_addr,
  input  logic [31:0] host_wdata,
  input  logic [3:0]  host_wrbits,
  output logic        host_ack,
  output logic [31:0] host_rdata,
  input  logic        host_lock,
  output logic        cpu_stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wrbits,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);
  localparam logic [CNT_W-1:0] RD_CNT = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] WR_CNT = CNT_W'(WR_LAT - 1);
  state_t             state_q, state_d;
  owner_t             last_grant_q, last_grant_d;
  owner_t             owner_q, owner_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         wrbits_q, wrbits_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cpu_ack_q, cpu_ack_d;
  logic               host_ack_q, host_ack_d;
  logic [31:0]        cpu_rdata_q, cpu_rdata_d;
  logic [31:0]        host_rdata_q, host_rdata_d;
  logic               grant_valid;
  owner_t             grant_owner;
  logic               sel_host;
  rr_pick2 u_pick (
    .eligible    ({host_req, cpu_req & ~host_lock}),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );
  assign sel_host = (grant_owner == HOST);
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wrbits_d     = wrbits_q;
    cnt_d        = cnt_q;
    cpu_ack_d    = 1'b0;
    host_ack_d   = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;
    case (state_q)
      IDLE: if (grant_valid) begin
        owner_d      = grant_owner;
        last_grant_d = grant_owner;
        we_d         = sel_host ? host_we : cpu_we;
        addr_d       = sel_host ? host_addr : cpu_addr;
        wdata_d      = sel_host ? host_wdata : cpu_wdata;
        // reads present an all-zero lane mask to memory
        wrbits_d     = we_d ? (sel_host ? host_wrbits : cpu_wrbits) : 4'b0000;
        cnt_d        = we_d ? WR_CNT : RD_CNT;
        state_d      = ACCESS;
      end
      ACCESS: if (cnt_q == '0) begin
        state_d      = DONE;
        cpu_ack_d    = (owner_q == CPU);
        host_ack_d   = (owner_q == HOST);
        cpu_rdata_d  = (!we_q && owner_q == CPU) ? mem_rdata : cpu_rdata_q;
        host_rdata_d = (!we_q && owner_q == HOST) ? mem_rdata : host_rdata_q;
      end else begin
        cnt_d        = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= HOST;
      owner_q      <= CPU;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wrbits_q     <= '0;
      cnt_q        <= '0;
      cpu_ack_q    <= 1'b0;
      host_ack_q   <= 1'b0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wrbits_q     <= wrbits_d;
      cnt_q        <= cnt_d;
      cpu_ack_q    <= cpu_ack_d;
      host_ack_q   <= host_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end
  // the write strobe fires only while cnt still holds its load value
  assign mem_read   = (state_q == ACCESS) & ~we_q;
  assign mem_write  = (state_q == ACCESS) & we_q & (cnt_q == WR_CNT);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wrbits = wrbits_q;
  assign cpu_ack    = cpu_ack_q;
  assign host_ack   = host_ack_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign host_rdata = host_rdata_q;
  assign cpu_stall  = cpu_req & ~cpu_ack_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter and its round-robin selector
module tb_mem_arbiter;
  import mem_arb_pkg::*;
  localparam int RD_LAT = 2;
  localparam int WR_LAT = 1;
  typedef struct {
    owner_t      owner;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wrbits;
  } txn_t;
  logic clock = 1'b0;
  logic reset;
  logic cpu_req, cpu_we, host_req, host_we, host_lock;
  logic [31:0] cpu_addr, cpu_wdata, host_addr, host_wdata;
  logic [3:0] cpu_wrbits, host_wrbits;
  logic cpu_ack, host_ack, cpu_stall, mem_read, mem_write;
  logic [31:0] cpu_rdata, host_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_wrbits;
  logic [1:0] rr_e;
  owner_t rr_lg, rr_o;
  logic rr_v;
  txn_t exp_q[$];
  txn_t t;
  int n_chk = 0;
  int n_pass = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  logic ack_prev = 1'b0;
  int lat, lat2;
  always #5 clock = ~clock;
  mem_arbiter #(.RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wrbits(cpu_wrbits), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_wrbits(host_wrbits), .host_ack(host_ack), .host_rdata(host_rdata),
    .host_lock(host_lock), .cpu_stall(cpu_stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wrbits(mem_wrbits),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );
  rr_pick2 u_rr (.eligible(rr_e), .last_grant(rr_lg), .grant_valid(rr_v), .grant_owner(rr_o));
  function automatic logic [31:0] rd_model(input logic [31:0] a);
    case (a)
      32'h100: return 32'hDEADBEEF;
      32'h300: return 32'h12345678;
      32'h400: return 32'h0;
      default: return {a[15:0], ~a[15:0]};
    endcase
  endfunction
  always_comb mem_rdata = rd_model(mem_addr);
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  function automatic void expect_txn(input owner_t o, input logic we, input logic [31:0] a,
                                     input logic [31:0] wd, input logic [3:0] wb);
    txn_t x;
    x.owner = o; x.we = we; x.addr = a; x.wdata = wd; x.wrbits = wb;
    exp_q.push_back(x);
  endfunction
  task automatic drive(input logic host, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] wb, output int lat_o);
    int n;
    if (host) begin
      host_we = we; host_addr = a; host_wdata = wd; host_wrbits = wb; host_req = 1'b1;
    end else begin
      cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_wrbits = wb; cpu_req = 1'b1;
    end
    n = 0;
    @(negedge clock);
    if (!host) check("cpu_stall", cpu_stall, !cpu_ack);
    while (!(host ? host_ack : cpu_ack) && n < 100) begin
      @(negedge clock);
      n++;
      if (!host) check("cpu_stall", cpu_stall, !cpu_ack);
    end
    if (n >= 100) check("ack_timeout", 0, 1);
    lat_o = n;
    @(posedge clock);
    #1;
    if (host) host_req = 1'b0;
    else cpu_req = 1'b0;
  endtask
  always @(negedge clock) begin
    if (!reset) begin
      exp_q.delete();
      rd_cnt = 0;
      wr_cnt = 0;
      ack_prev = 1'b0;
    end else begin
      if (mem_read || mem_write) begin
        if (exp_q.size() == 0) check("mem_unexpected", 1, 0);
        else begin
          t = exp_q[0];
          check("mem_addr", mem_addr, t.addr);
          check("mem_strobe", {mem_read, mem_write}, t.we ? 2'b01 : 2'b10);
          if (t.we) begin
            check("mem_wdata", mem_wdata, t.wdata);
            check("mem_wrbits", mem_wrbits, t.wrbits);
          end else check("mem_rd_wrbits", mem_wrbits, 4'b0000);
        end
        rd_cnt += int'(mem_read);
        wr_cnt += int'(mem_write);
      end
      if (cpu_ack || host_ack) begin
        check("ack_width", ack_prev, 1'b0);
        if (exp_q.size() == 0) check("ack_unexpected", 1, 0);
        else begin
          t = exp_q.pop_front();
          check("ack_owner", {host_ack, cpu_ack}, t.owner == HOST ? 2'b10 : 2'b01);
          if (!t.we) check("rdata", t.owner == HOST ? host_rdata : cpu_rdata, rd_model(t.addr));
          check("strobe_cycles", t.we ? wr_cnt : rd_cnt, t.we ? 1 : RD_LAT);
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
      ack_prev = cpu_ack | host_ack;
    end
  end
  initial begin
    reset = 1'b0;
    {cpu_req, cpu_we, host_req, host_we, host_lock} = '0;
    {cpu_addr, cpu_wdata, host_addr, host_wdata} = '0;
    cpu_wrbits = '0;
    host_wrbits = '0;
    for (int i = 0; i < 8; i++) begin
      rr_e = i[1:0];
      rr_lg = owner_t'(i[2]);
      #1;
      check("rr_valid", rr_v, |rr_e);
      if (|rr_e)
        check("rr_owner", rr_o, (rr_e == 2'b11) ? (rr_lg == CPU ? HOST : CPU) : (rr_e[1] ? HOST : CPU));
    end
    repeat (3) @(posedge clock);
    #1;
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_wrbits", mem_wrbits, 0);
    check("rst_strobes", {mem_read, mem_write}, 2'b00);
    check("rst_acks", {cpu_ack, host_ack}, 2'b00);
    check("rst_rdata", {cpu_rdata, host_rdata}, 64'h0);
    @(negedge clock) reset = 1'b1;
    @(posedge clock);
    #1;
    expect_txn(CPU, 1'b0, 32'h100, 32'h0, 4'h0);
    drive(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, lat);
    check("rd_latency", lat, RD_LAT + 1);
    expect_txn(CPU, 1'b1, 32'h204, 32'hAA, 4'b0001);
    drive(1'b0, 1'b1, 32'h204, 32'hAA, 4'b0001, lat);
    check("wr_latency", lat, WR_LAT + 1);
    expect_txn(HOST, 1'b1, 32'h208, 32'h5555, 4'b1100);
    drive(1'b1, 1'b1, 32'h208, 32'h5555, 4'b1100, lat);
    check("host_wr_latency", lat, WR_LAT + 1);
    expect_txn(CPU, 1'b0, 32'h10, 32'h0, 4'h0);
    expect_txn(HOST, 1'b0, 32'h20, 32'h0, 4'h0);
    expect_txn(CPU, 1'b1, 32'h14, 32'hCAFE, 4'b1111);
    expect_txn(HOST, 1'b0, 32'h24, 32'h0, 4'h0);
    fork
      begin
        drive(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, lat);
        drive(1'b0, 1'b1, 32'h14, 32'hCAFE, 4'b1111, lat);
      end
      begin
        drive(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, lat2);
        drive(1'b1, 1'b0, 32'h24, 32'h0, 4'h0, lat2);
      end
    join
    host_lock = 1'b1;
    for (int i = 0; i < 3; i++) expect_txn(HOST, 1'b0, 32'h30 + 32'(4 * i), 32'h0, 4'h0);
    expect_txn(CPU, 1'b0, 32'h40, 32'h0, 4'h0);
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          drive(1'b1, 1'b0, 32'h30 + 32'(4 * i), 32'h0, 4'h0, lat2);
          check("lock_stall", cpu_stall, 1'b1);
        end
        host_lock = 1'b0;
      end
      drive(1'b0, 1'b0, 32'h40, 32'h0, 4'h0, lat);
    join
    expect_txn(CPU, 1'b0, 32'h100, 32'h0, 4'h0);
    cpu_we = 1'b0; cpu_addr = 32'h100; cpu_req = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("abort_pre_read", mem_read, 1'b1);
    #1;
    reset = 1'b0;
    cpu_req = 1'b0;
    #1;
    check("abort_strobes", {mem_read, mem_write}, 2'b00);
    check("abort_ack", {cpu_ack, host_ack}, 2'b00);
    check("abort_addr", mem_addr, 0);
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("abort_no_ack", {cpu_ack, host_ack}, 2'b00);
    end
    @(posedge clock);
    #1;
    expect_txn(CPU, 1'b0, 32'h50, 32'h0, 4'h0);
    expect_txn(HOST, 1'b0, 32'h60, 32'h0, 4'h0);
    fork
      drive(1'b0, 1'b0, 32'h50, 32'h0, 4'h0, lat);
      drive(1'b1, 1'b0, 32'h60, 32'h0, 4'h0, lat2);
    join
    check("post_rst_cpu_lat", lat, RD_LAT + 1);
    expect_txn(HOST, 1'b0, 32'h300, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 32'h300, 32'h0, 4'h0, lat2);
    expect_txn(CPU, 1'b0, 32'h400, 32'h0, 4'h0);
    drive(1'b0, 1'b0, 32'h400, 32'h0, 4'h0, lat);
    repeat (3) @(posedge clock);
    #1;
    check("host_rdata_hold", host_rdata, 32'h12345678);
    check("cpu_rdata_zero", cpu_rdata, 32'h0);
    check("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
